// File: rtl/proc_pkg.sv
// Shared state type, counter width and id-width helper for the interrupt controller.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2,
        SERVICE  = 2'd3
    } irq_state_t;

    localparam int DRAIN_CNT_W = 4;

    function automatic int irq_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_controller_prio.sv
// Combinational lowest-index-first priority encoder: request vector -> valid, id.
module irq_priority_enc
    import proc_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = irq_id_w(N)
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        id_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) id_o = ID_W'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/irq_controller.sv
// Multi-channel interrupt controller: edge latch, mask, priority pick, drain, vector redirect, mret return.
// Build option IRQ_SYNC_EN adds a 2-flop synchronizer per line ahead of edge detection.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | waiting for an enabled pending channel while global_en is high
//  DRAIN    | fetch stalled, counting down DRAIN_CYCLES
//  REDIRECT | fetch stalled, redirect strobe once pipe_hold is low
//  SERVICE  | handler running, waiting for mret
module irq_controller
    import proc_pkg::*;
#(
    parameter int              NUM_IRQ      = 4,
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] VEC_BASE     = 'h0000_0100,
    parameter int              VEC_STRIDE   = 16,
    parameter int              DRAIN_CYCLES = 3,
    localparam int             ID_W         = irq_id_w(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               global_en,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               pipe_hold,
    input  logic [XLEN-1:0]    epc_in,
    input  logic               mret,
    output logic               stall_fetch,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_addr,
    output logic               ret_valid,
    output logic [XLEN-1:0]    ret_addr,
    output logic               in_service,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0]     irq_s;
    logic [NUM_IRQ-1:0]     irq_q;
    logic [NUM_IRQ-1:0]     pending_q, pending_d;
    logic [NUM_IRQ-1:0]     mask_q;
    logic [NUM_IRQ-1:0]     rise;
    logic [NUM_IRQ-1:0]     clr_vec;
    irq_state_t             state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]        sel_q, sel_d;
    logic [XLEN-1:0]        epc_q, epc_d;
    logic                   req_valid;
    logic [ID_W-1:0]        req_id;
    logic                   fire;
    logic                   ret;
    logic [XLEN-1:0]        vec_addr;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    assign rise = irq_s & ~irq_q;

    irq_priority_enc #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio (
        .req_i   (pending_q & mask_q),
        .valid_o (req_valid),
        .id_o    (req_id)
    );

    // A fresh edge on the channel being redirected re-pends it: set wins over clear.
    assign clr_vec   = fire ? (NUM_IRQ'(1) << sel_q) : '0;
    assign pending_d = (pending_q & ~clr_vec) | rise;

    assign vec_addr = VEC_BASE + XLEN'(sel_q) * XLEN'(VEC_STRIDE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        epc_d   = epc_q;
        fire    = 1'b0;
        ret     = 1'b0;
        case (state_q)
            IDLE: begin
                if (global_en && req_valid) begin
                    state_d = DRAIN;
                    sel_d   = req_id;
                    cnt_d   = DRAIN_CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (cnt_q <= DRAIN_CNT_W'(1)) begin
                    state_d = REDIRECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DRAIN_CNT_W'(1);
                end
            end
            REDIRECT: begin
                if (!pipe_hold) begin
                    fire    = 1'b1;
                    epc_d   = epc_in;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (mret) begin
                    ret     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            epc_q     <= '0;
        end else begin
            irq_q     <= irq_s;
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_wdata;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            epc_q     <= epc_d;
        end
    end

    assign stall_fetch   = (state_q == DRAIN) || (state_q == REDIRECT);
    assign redirect      = fire;
    assign redirect_addr = fire ? vec_addr : '0;
    assign ret_valid     = ret;
    assign ret_addr      = epc_q;
    assign in_service    = (state_q == SERVICE);
    assign irq_id        = in_service ? sel_q : '0;
    assign pending       = pending_q;

endmodule
